// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch sequencer: reads opcode and up to two operand
// bytes, sizes the instruction via an external length decoder, and hands it off.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  dec_opcode,
    input  logic [1:0]  dec_len,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [7:0]  inst_opcode,
    output logic [15:0] inst_operand,
    output logic [1:0]  inst_len,
    output logic [15:0] inst_pc,
    output logic [15:0] pc
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_OP = 3'd1,
        FETCH_LO = 3'd2,
        FETCH_HI = 3'd3,
        HOLD     = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] operand_q, operand_d;
    logic [15:0] inst_pc_q, inst_pc_d;
    logic [1:0]  len_q, len_d;
    logic [1:0]  dec_len_norm;

    // The decoder reports 0 for single-byte opcodes as well as 1.
    assign dec_len_norm = (dec_len == 2'd0) ? 2'd1 : dec_len;

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        inst_pc_d = inst_pc_q;
        len_d     = len_q;

        if (redirect) begin
            // Redirect wins over any same-cycle ack: the byte is dropped and pc not bumped.
            state_d = FETCH_OP;
            pc_d    = redirect_pc;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) state_d = FETCH_OP;
                end
                FETCH_OP: begin
                    if (mem_ack) begin
                        opcode_d  = mem_rdata;
                        inst_pc_d = pc_q;
                        operand_d = 16'h0000;
                        len_d     = dec_len_norm;
                        pc_d      = pc_q + 16'd1;
                        state_d   = (dec_len_norm == 2'd1) ? HOLD : FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (mem_ack) begin
                        operand_d[7:0] = mem_rdata;
                        pc_d           = pc_q + 16'd1;
                        state_d        = (len_q == 2'd2) ? HOLD : FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (mem_ack) begin
                        operand_d[15:8] = mem_rdata;
                        pc_d            = pc_q + 16'd1;
                        state_d         = HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ready) state_d = run ? FETCH_OP : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            opcode_q  <= 8'h00;
            operand_q <= 16'h0000;
            inst_pc_q <= 16'h0000;
            len_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            inst_pc_q <= inst_pc_d;
            len_q     <= len_d;
        end
    end

    assign mem_req      = (state_q == FETCH_OP) || (state_q == FETCH_LO) || (state_q == FETCH_HI);
    assign mem_addr     = pc_q;
    assign dec_opcode   = (state_q == FETCH_OP) ? mem_rdata : opcode_q;
    assign inst_valid   = (state_q == HOLD);
    assign inst_opcode  = opcode_q;
    assign inst_operand = operand_q;
    assign inst_len     = len_q;
    assign inst_pc      = inst_pc_q;
    assign pc           = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: bench plays memory and length decoder,
// all expected values hand-computed.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, mem_req, mem_ack, redirect, inst_valid, inst_ready;
    logic [15:0] mem_addr, redirect_pc, inst_operand, inst_pc, pc;
    logic [7:0]  mem_rdata, dec_opcode, inst_opcode;
    logic [1:0]  dec_len, inst_len;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0;

    fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dec_opcode(dec_opcode), .dec_len(dec_len),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_opcode(inst_opcode), .inst_operand(inst_operand), .inst_len(inst_len),
        .inst_pc(inst_pc), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One memory byte: 'waits' stall cycles then an ack cycle; address must hold.
    task automatic fetch_byte(input logic [15:0] addr, input logic [7:0] data,
                              input int waits, input bit is_op, input logic [1:0] len);
        for (int i = 0; i < waits; i++) begin
            mem_ack = 1'b0;
            #1;
            check("wait_req", mem_req, 1'b1);
            check("wait_addr", mem_addr, addr);
            check("wait_valid", inst_valid, 1'b0);
            step();
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        if (is_op) dec_len = len;
        #1;
        check("ack_req", mem_req, 1'b1);
        check("ack_addr", mem_addr, addr);
        if (is_op) check("dec_opcode", dec_opcode, data);
        step();
        mem_ack = 1'b0;
    endtask

    task automatic check_inst(input logic [7:0] op, input logic [15:0] opnd,
                              input logic [1:0] len, input logic [15:0] ipc, input logic [15:0] npc);
        #1;
        check("valid", inst_valid, 1'b1);
        check("opcode", inst_opcode, op);
        check("operand", inst_operand, opnd);
        check("len", inst_len, len);
        check("inst_pc", inst_pc, ipc);
        check("pc", pc, npc);
        check("hold_req", mem_req, 1'b0);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; dec_len = 2'd0;
        redirect = 1'b0; redirect_pc = 16'h0000; inst_ready = 1'b0;
        #1;
        step(); step();
        #1;
        check("rst_req", mem_req, 1'b0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_pc", pc, 16'h0000);
        check("rst_opcode", inst_opcode, 8'h00);
        check("rst_operand", inst_operand, 16'h0000);
        check("rst_len", inst_len, 2'd0);
        check("rst_inst_pc", inst_pc, 16'h0000);

        // 2-byte A9 05, zero-wait
        reset = 1'b0; run = 1'b1;
        #1;
        check("idle_req", mem_req, 1'b0);
        step();
        fetch_byte(16'h0000, 8'hA9, 0, 1'b1, 2'd2);
        fetch_byte(16'h0001, 8'h05, 0, 1'b0, 2'd0);
        check_inst(8'hA9, 16'h0005, 2'd2, 16'h0000, 16'h0002);

        // Consumer stalls 5 cycles, accepts on the 6th
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", inst_valid, 1'b1);
            check("stall_req", mem_req, 1'b0);
            check("stall_opcode", inst_opcode, 8'hA9);
            check("stall_operand", inst_operand, 16'h0005);
            step();
        end
        inst_ready = 1'b1;
        #1;
        check("xfer_valid", inst_valid, 1'b1);
        step();
        inst_ready = 1'b0;
        #1;
        check("next_req", mem_req, 1'b1);
        check("next_addr", mem_addr, 16'h0002);

        // 3-byte 4C 34 12 with 3 wait cycles per byte
        t0 = cyc;
        fetch_byte(16'h0002, 8'h4C, 3, 1'b1, 2'd3);
        fetch_byte(16'h0003, 8'h34, 3, 1'b0, 2'd0);
        fetch_byte(16'h0004, 8'h12, 3, 1'b0, 2'd0);
        check("latency3", cyc - t0, 12);
        check_inst(8'h4C, 16'h1234, 2'd3, 16'h0002, 16'h0005);
        run = 1'b0; inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        #1;
        check("to_idle_req", mem_req, 1'b0);
        check("to_idle_valid", inst_valid, 1'b0);

        // Redirect from IDLE (run low) to FFFF, 2-byte instruction wraps
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        #1;
        check("idle_redir_req", mem_req, 1'b1);
        check("idle_redir_addr", mem_addr, 16'hFFFF);
        fetch_byte(16'hFFFF, 8'h85, 0, 1'b1, 2'd2);
        fetch_byte(16'h0000, 8'h10, 0, 1'b0, 2'd0);
        check_inst(8'h85, 16'h0010, 2'd2, 16'hFFFF, 16'h0001);
        run = 1'b1; inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;

        // 1-byte opcode, decoder reports 0
        t0 = cyc;
        fetch_byte(16'h0001, 8'hEA, 0, 1'b1, 2'd0);
        check("latency1", cyc - t0, 1);
        check_inst(8'hEA, 16'h0000, 2'd1, 16'h0001, 16'h0002);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;

        // Redirect to C000 while FETCH_LO is acked
        fetch_byte(16'h0002, 8'hA9, 0, 1'b1, 2'd2);
        mem_ack = 1'b1; mem_rdata = 8'h77; redirect = 1'b1; redirect_pc = 16'hC000;
        #1;
        check("abort_addr", mem_addr, 16'h0003);
        step();
        mem_ack = 1'b0; redirect = 1'b0;
        #1;
        check("abort_pc", pc, 16'hC000);
        check("abort_addr2", mem_addr, 16'hC000);
        check("abort_valid", inst_valid, 1'b0);
        fetch_byte(16'hC000, 8'hEA, 0, 1'b1, 2'd1);
        check_inst(8'hEA, 16'h0000, 2'd1, 16'hC000, 16'hC001);

        // Redirect coinciding with a transfer
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h1000;
        step();
        inst_ready = 1'b0; redirect = 1'b0;
        #1;
        check("xr_valid", inst_valid, 1'b0);
        check("xr_addr", mem_addr, 16'h1000);

        // Reset in FETCH_HI, then a late ack
        fetch_byte(16'h1000, 8'h4C, 0, 1'b1, 2'd3);
        fetch_byte(16'h1001, 8'h34, 0, 1'b0, 2'd0);
        #1;
        check("hi_req", mem_req, 1'b1);
        check("hi_addr", mem_addr, 16'h1002);
        reset = 1'b1;
        step();
        reset = 1'b0; run = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h12;
        #1;
        check("late_req", mem_req, 1'b0);
        check("late_valid", inst_valid, 1'b0);
        check("late_pc", pc, 16'h0000);
        step();
        mem_ack = 1'b0;
        #1;
        check("late_pc2", pc, 16'h0000);
        check("late_valid2", inst_valid, 1'b0);
        check("late_req2", mem_req, 1'b0);
        check("late_opcode", inst_opcode, 8'h00);
        check("late_len", inst_len, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
